// File: rtl/updi_pkg.sv
// Shared UPDI definitions: frame width, scheduler state encoding and the SYNCH byte.
package updi_pkg;

    localparam int FRAME_W = 12;
    localparam logic [7:0] UPDI_SYNCH = 8'h55;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        GUARD  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/updi_guard_timer.sv
// Idle guard-time counter: load, decrement that saturates at zero, and a zero flag.
module updi_guard_timer #(
    parameter int GUARD_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [GUARD_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero
);

    logic [GUARD_W-1:0] cnt_q;

    // Load wins over decrement; decrement never wraps below zero.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/updi_tx_sched.sv
// Round-robin, per-packet scheduler sharing one UPDI frame serializer between two
// requesters, with a one-entry output register and a programmable post-packet guard.
//
// Handshakes: a transfer happens on any cycle where valid && ready are both high at
// the rising edge; the producer holds valid and data stable until that cycle, and
// ready never depends combinationally on the same interface's valid.
module updi_tx_sched #(
    parameter int GUARD_W = 8,
    parameter int FRAME_W = updi_pkg::FRAME_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [FRAME_W-1:0]    i_req0_data,
    input  logic                  i_req0_valid,
    input  logic                  i_req0_last,
    output logic                  o_req0_ready,
    input  logic [FRAME_W-1:0]    i_req1_data,
    input  logic                  i_req1_valid,
    input  logic                  i_req1_last,
    output logic                  o_req1_ready,
    input  logic [GUARD_W-1:0]    i_guard_cycles,
    output logic [FRAME_W-1:0]    o_frame,
    output logic                  o_frame_valid,
    input  logic                  i_frame_ready,
    output logic                  o_owner,
    output logic                  o_busy,
    output updi_pkg::sched_state_t o_state
);

    import updi_pkg::*;

    sched_state_t       state_q, state_d;
    logic               rr_q, rr_d;
    logic               owner_q, owner_d;
    logic [FRAME_W-1:0] frame_q;
    logic               frame_valid_q;
    logic               guard_load;
    logic               guard_dec;
    logic               guard_zero;
    logic               hs0, hs1, hs;
    logic [FRAME_W-1:0] hs_data;
    logic               hs_last;
    logic               slot_free;

    // The holding register can take a new frame when empty or when it drains this cycle.
    assign slot_free    = !frame_valid_q || i_frame_ready;
    assign o_req0_ready = (state_q == GRANT0) && slot_free;
    assign o_req1_ready = (state_q == GRANT1) && slot_free;

    assign hs0     = o_req0_ready && i_req0_valid;
    assign hs1     = o_req1_ready && i_req1_valid;
    assign hs      = hs0 || hs1;
    assign hs_data = hs1 ? i_req1_data : i_req0_data;
    assign hs_last = hs1 ? i_req1_last : i_req0_last;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        guard_load = 1'b0;
        case (state_q)
            IDLE: begin
                // rr only moves when both requesters compete.
                if (i_req0_valid && i_req1_valid) begin
                    owner_d = rr_q;
                    rr_d    = ~rr_q;
                    state_d = rr_q ? GRANT1 : GRANT0;
                end else if (i_req0_valid) begin
                    owner_d = 1'b0;
                    state_d = GRANT0;
                end else if (i_req1_valid) begin
                    owner_d = 1'b1;
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (hs && hs_last) begin
                    guard_load = 1'b1;
                    state_d    = GUARD;
                end
            end
            GUARD: begin
                if (!frame_valid_q && guard_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Guard time only counts once the last frame has left the holding register.
    assign guard_dec = (state_q == GUARD) && !frame_valid_q;

    updi_guard_timer #(
        .GUARD_W(GUARD_W)
    ) u_guard_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (guard_load),
        .i_load_val (i_guard_cycles),
        .i_dec      (guard_dec),
        .o_zero     (guard_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
        end else if (hs) begin
            frame_q       <= hs_data;
            frame_valid_q <= 1'b1;
        end else if (i_frame_ready) begin
            frame_valid_q <= 1'b0;
        end
    end

    assign o_frame       = frame_q;
    assign o_frame_valid = frame_valid_q;
    assign o_owner       = owner_q;
    assign o_busy        = (state_q != IDLE) || frame_valid_q;
    assign o_state       = state_q;

endmodule
